// File: rtl/can_bus_fabric.sv
// can_bus_fabric: wired-OR CAN bus resolver with configurable propagation
// delay, idle / start-of-frame / stuck-dominant monitors and a run counter.
// Optional feature macro: CAN_BUS_FAULT_INJECT_EN (forces inj_val onto the
// bus after the delay line while inj_en is high).

// Per-node driver gate: an isolated node cannot pull the bus dominant.
module can_bus_tap (
  input  logic hi,
  input  logic en,
  output logic drv
);
  assign drv = hi & en;
endmodule

module can_bus_fabric #(
  parameter int NODES      = 2,
  parameter int DELAY      = 0,
  parameter int IDLE_BITS  = 11,
  parameter int STUCK_BITS = 17,
  parameter int RUN_LEN    = 120
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NODES-1:0] hi_out,
  input  logic [NODES-1:0] node_en,
  input  logic             inj_en,
  input  logic             inj_val,
  output logic             can_hi,
  output logic             can_lo,
  output logic             bus_idle,
  output logic [15:0]      sof_count,
  output logic             stuck_err,
  output logic [15:0]      cyc,
  output logic             done
);
  localparam int PW = DELAY + 1;
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int SW = $clog2(STUCK_BITS + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_BITS);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_BITS);
  localparam logic [SW-1:0] STUCK_PRE = SW'(STUCK_BITS - 1);
  localparam logic [15:0]   RUN_MAX   = 16'(RUN_LEN);

  logic [NODES-1:0] drv;
  logic             raw;
  logic [DELAY:0]   bus_pipe;
  logic [IW-1:0]    idle_cnt;
  logic [SW-1:0]    dom_cnt;

  can_bus_tap u_tap [NODES-1:0] (
    .hi  (hi_out),
    .en  (node_en),
    .drv (drv)
  );

  assign raw = |drv;

  // Delay line: stage 0 registers raw, stage DELAY feeds the bus.
  always_ff @(posedge CLK) begin
    if (RST) bus_pipe <= '0;
    else     bus_pipe <= PW'({bus_pipe, raw});
  end

`ifdef CAN_BUS_FAULT_INJECT_EN
  // Injection overrides the last stage combinationally, so it adds no latency.
  assign can_hi = inj_en ? inj_val : bus_pipe[DELAY];
`else
  logic unused_inj;
  assign unused_inj = inj_en ^ inj_val;
  assign can_hi     = bus_pipe[DELAY];
`endif

  assign can_lo   = ~can_hi;
  assign bus_idle = (idle_cnt == IDLE_MAX);

  // Bus monitors: recessive/dominant run lengths, SOF count, sticky stuck flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt  <= IDLE_MAX;
      dom_cnt   <= '0;
      sof_count <= '0;
      stuck_err <= 1'b0;
    end else if (can_hi) begin
      // The dominant bit also clears idle, so one idle period yields one SOF.
      idle_cnt <= '0;
      if (bus_idle) sof_count <= sof_count + 16'd1;
      if (dom_cnt != STUCK_MAX) dom_cnt <= dom_cnt + SW'(1);
      if (dom_cnt >= STUCK_PRE) stuck_err <= 1'b1;
    end else begin
      dom_cnt <= '0;
      if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Run-length counter: counts up to RUN_LEN then holds.
  always_ff @(posedge CLK) begin
    if (RST)                cyc <= '0;
    else if (cyc < RUN_MAX) cyc <= cyc + 16'd1;
  end

  assign done = (cyc == RUN_MAX);
endmodule
